// File: rtl/sr_ff_monitor.sv
// Cycle-accurate checker for the T-flip-flop-based SR cell: tracks the expected Q,
// flags divergences and illegal s=r=1 usage, and latches a sticky fault.
module sr_ff_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FAULT_LIMIT = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             clr_err,
  input  logic             s,
  input  logic             r,
  input  logic             qsr,
  input  logic             qsrbar,
  output logic             exp_q,
  output logic             err_pulse,
  output logic             fault,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(FAULT_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             exp_q_q, exp_q_d;
  logic             err_q, err_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             mismatch_c;
  logic             illegal_c;

  // Next Q of the SR cell, expressed through its internal toggle enable.
  function automatic logic sr_next(input logic q, input logic set, input logic rst);
    logic t;
    t = (set & ~q) | (rst & q);
    return q ^ t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign mismatch_c = (qsr != exp_q_q) | (qsrbar != ~qsr);
  assign illegal_c  = s & r;

  always_comb begin
    state_d = state_q;
    exp_q_d = exp_q_q;
    err_d   = 1'b0;
    mcnt_d  = mcnt_q;
    icnt_d  = icnt_q;

    if (clr_err) begin
      state_d = ST_IDLE;
      exp_q_d = 1'b0;
      mcnt_d  = '0;
      icnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (en) begin
            exp_q_d = sr_next(qsr, s, r);
            state_d = ST_CHECK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (illegal_c) icnt_d = sat_inc(icnt_q);
          // On divergence, resync to the observed Q so one event counts once.
          if (mismatch_c) begin
            err_d   = 1'b1;
            mcnt_d  = sat_inc(mcnt_q);
            exp_q_d = sr_next(qsr, s, r);
          end else begin
            exp_q_d = sr_next(exp_q_q, s, r);
          end
          if (mismatch_c && (mcnt_d == LIMIT_CNT)) state_d = ST_FAULT;
          else if (!en)                            state_d = ST_IDLE;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      exp_q_q <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      mcnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q_q <= exp_q_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      mcnt_q  <= mcnt_d;
      icnt_q  <= icnt_d;
    end
  end

  assign exp_q        = exp_q_q;
  assign err_pulse    = err_q;
  assign fault        = fault_q;
  assign mismatch_cnt = mcnt_q;
  assign illegal_cnt  = icnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Randomized scoreboard bench for sr_ff_monitor against a behavioural model of its rules.
module tb_sr_ff_monitor;

  localparam int unsigned CNT_W       = 3;
  localparam int unsigned FAULT_LIMIT = 4;
  localparam int          CNT_MAXV    = (1 << CNT_W) - 1;
  localparam int          N_CYCLES    = 4000;

  logic             clk, clr, en, clr_err, s, r, qsr, qsrbar;
  logic             exp_q, err_pulse, fault;
  logic [CNT_W-1:0] mismatch_cnt, illegal_cnt;
  logic [1:0]       state;

  sr_ff_monitor #(.CNT_W(CNT_W), .FAULT_LIMIT(FAULT_LIMIT)) dut (
    .clk(clk), .clr(clr), .en(en), .clr_err(clr_err), .s(s), .r(r),
    .qsr(qsr), .qsrbar(qsrbar), .exp_q(exp_q), .err_pulse(err_pulse),
    .fault(fault), .mismatch_cnt(mismatch_cnt), .illegal_cnt(illegal_cnt),
    .state(state)
  );

  typedef struct {
    int mode;
    int expq;
    int err;
    int flt;
    int mcnt;
    int icnt;
  } mdl_t;

  mdl_t mdl;
  mdl_t exp_q_fifo[$];
  int   tests, fails;
  int   cell_q;
  int   cyc;
  bit   done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SR behaviour as a plain truth table: hold, set, reset, toggle.
  function automatic int sr_rule(int q, int ss, int rr);
    if (ss == 1 && rr == 1) return 1 - q;
    if (ss == 1)            return 1;
    if (rr == 1)            return 0;
    return q;
  endfunction

  function automatic mdl_t zero_mdl();
    mdl_t z;
    z.mode = 0; z.expq = 0; z.err = 0; z.flt = 0; z.mcnt = 0; z.icnt = 0;
    return z;
  endfunction

  function automatic mdl_t step(mdl_t m, int c, int ce, int e, int ss, int rr, int q, int qb);
    mdl_t n;
    int   bad;
    n = m;
    n.err = 0;
    if (c == 0 || ce == 1) return zero_mdl();
    if (m.mode == 0) begin
      if (e == 1) n.mode = 1;
    end else if (m.mode == 1) begin
      if (e == 1) begin
        n.expq = sr_rule(q, ss, rr);
        n.mode = 2;
      end else n.mode = 0;
    end else if (m.mode == 2) begin
      bad = (q != m.expq || qb == q) ? 1 : 0;
      if (ss == 1 && rr == 1 && m.icnt < CNT_MAXV) n.icnt = m.icnt + 1;
      if (bad == 1) begin
        n.err  = 1;
        if (m.mcnt < CNT_MAXV) n.mcnt = m.mcnt + 1;
        n.expq = sr_rule(q, ss, rr);
        if (n.mcnt == FAULT_LIMIT) n.mode = 3;
        else if (e == 0) n.mode = 0;
      end else begin
        n.expq = sr_rule(m.expq, ss, rr);
        if (e == 0) n.mode = 0;
      end
    end
    n.flt = (n.mode == 3) ? 1 : 0;
    return n;
  endfunction

  // Model and ideal SR cell both sample the pre-edge inputs.
  always @(posedge clk) begin
    mdl = step(mdl, int'(clr), int'(clr_err), int'(en), int'(s), int'(r),
               int'(qsr), int'(qsrbar));
    exp_q_fifo.push_back(mdl);
    cell_q = sr_rule(cell_q, int'(s), int'(r));
  end

  // Scoreboard monitor: the DUT presents a full output set every cycle.
  always @(negedge clk) begin
    mdl_t e;
    logic [2*CNT_W+4:0] act, req;
    if (exp_q_fifo.size() != 0) begin
      e   = exp_q_fifo.pop_front();
      act = {state, fault, err_pulse, exp_q, mismatch_cnt, illegal_cnt};
      req = {2'(e.mode), 1'(e.flt), 1'(e.err), 1'(e.expq), CNT_W'(e.mcnt), CNT_W'(e.icnt)};
      tests++;
      if (act !== req) begin
        fails++;
        $display("FAIL outputs t=%0t {state,fault,err,expq,mcnt,icnt} actual=%0d,%0b,%0b,%0b,%0d,%0d required=%0d,%0d,%0d,%0d,%0d,%0d",
                 $time, state, fault, err_pulse, exp_q, mismatch_cnt, illegal_cnt,
                 e.mode, e.flt, e.err, e.expq, e.mcnt, e.icnt);
      end
    end
  end

  task automatic drive_random(int inj_pct, int cerr_pct, int clr_pct);
    int flip;
    s       = 1'($urandom_range(0, 1));
    r       = 1'($urandom_range(0, 1));
    en      = ($urandom_range(0, 99) < 92) ? 1'b1 : 1'b0;
    clr_err = ($urandom_range(0, 999) < cerr_pct) ? 1'b1 : 1'b0;
    clr     = ($urandom_range(0, 999) < clr_pct) ? 1'b0 : 1'b1;
    flip    = ($urandom_range(0, 99) < inj_pct) ? 1 : 0;
    qsr     = 1'(cell_q ^ flip);
    qsrbar  = ($urandom_range(0, 99) < inj_pct / 2) ? qsr : ~qsr;
  endtask

  initial begin
    mdl    = zero_mdl();
    tests  = 0;
    fails  = 0;
    cell_q = 0;
    done   = 1'b0;
    clr = 1'b0; en = 1'b0; clr_err = 1'b0;
    s = 1'b0; r = 1'b0; qsr = 1'b0; qsrbar = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    en  = 1'b1;
    // Clean directed run: 10,00,01,00,11,11 with a well-behaved cell.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin s = 1'b1; r = 1'b0; end
        1: begin s = 1'b0; r = 1'b0; end
        2: begin s = 1'b0; r = 1'b1; end
        3: begin s = 1'b0; r = 1'b0; end
        4: begin s = 1'b1; r = 1'b1; end
        5: begin s = 1'b1; r = 1'b1; end
        default: begin s = 1'b0; r = 1'b0; end
      endcase
      qsr = 1'(cell_q); qsrbar = ~qsr;
    end
    // clr_err coincident with a forced mismatch, then reset with clr_err high.
    @(posedge clk); #1;
    qsr = ~1'(cell_q); qsrbar = ~qsr; clr_err = 1'b1;
    @(posedge clk); #1;
    qsr = 1'(cell_q); qsrbar = ~qsr; clr_err = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b0; clr_err = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1; clr_err = 1'b0;
    for (cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk); #1;
      if (cyc < N_CYCLES / 2) drive_random(4, 8, 3);
      else                    drive_random(15, 20, 5);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q_fifo.size() > 1) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d entries required<=1", exp_q_fifo.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
